// File: rtl/aes_encipher_block.sv
// AES block encipher datapath: one time-shared word S-box, round counter driving
// an external key schedule, AES-128 / AES-256 selected at run time.
`default_nettype none

module aes_sbox (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign word_o = {sub_byte(word_i[31:24]), sub_byte(word_i[23:16]),
                     sub_byte(word_i[15:8]),  sub_byte(word_i[7:0])};
endmodule

module aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [1:0]     word_q, word_d;
    logic           ready_q, ready_d;
    logic           keylen_q, keylen_d;
    logic [127:0]   block_q, block_d;
    logic [31:0]    sbox_in, sbox_out;
    logic [3:0]     num_rounds;

    function automatic logic [7:0] gm2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] a);
        return gm2(a) ^ a;
    endfunction

    // Byte k of column c sits at bits [127-8*(4c+k) -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                r[127-8*(4*c+k) -: 8] = s[127-8*(4*((c+k)%4)+k) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
                                 a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
                                 a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
                                 gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
        end
        return r;
    endfunction

    aes_sbox u_sbox (
        .word_i (sbox_in),
        .word_o (sbox_out)
    );

    always_comb begin
        sbox_in = block_q[127:96];
        case (word_q)
            2'd0: sbox_in = block_q[127:96];
            2'd1: sbox_in = block_q[95:64];
            2'd2: sbox_in = block_q[63:32];
            2'd3: sbox_in = block_q[31:0];
            default: sbox_in = block_q[127:96];
        endcase
    end

    assign num_rounds = keylen_q ? 4'd14 : 4'd10;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        word_d   = word_q;
        ready_d  = ready_q;
        keylen_d = keylen_q;
        block_d  = block_q;
        case (state_q)
            IDLE: begin
                if (next) begin
                    round_d  = 4'd0;
                    keylen_d = keylen;
                    ready_d  = 1'b0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                block_d = block ^ round_key;
                word_d  = 2'd0;
                round_d = 4'd1;
                state_d = SBOX;
            end
            SBOX: begin
                case (word_q)
                    2'd0: block_d[127:96] = sbox_out;
                    2'd1: block_d[95:64]  = sbox_out;
                    2'd2: block_d[63:32]  = sbox_out;
                    2'd3: block_d[31:0]   = sbox_out;
                    default: block_d[127:96] = sbox_out;
                endcase
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) state_d = MAIN;
            end
            MAIN: begin
                if (round_q < num_rounds) begin
                    block_d = mix_columns(shift_rows(block_q)) ^ round_key;
                    round_d = round_q + 4'd1;
                    word_d  = 2'd0;
                    state_d = SBOX;
                end else begin
                    // Final round omits MixColumns; round stays at Nr for the key schedule.
                    block_d = shift_rows(block_q) ^ round_key;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            round_q  <= 4'd0;
            word_q   <= 2'd0;
            ready_q  <= 1'b1;
            keylen_q <= 1'b0;
            block_q  <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            word_q   <= word_d;
            ready_q  <= ready_d;
            keylen_q <= keylen_d;
            block_q  <= block_d;
        end
    end

    assign round     = round_q;
    assign new_block = block_q;
    assign ready     = ready_q;
endmodule

`default_nettype wire
